// File: rtl/bht_update_queue.sv
// bht_update_queue
//   Decouples resolved-branch updates coming out of execute from the BHT
//   write port. Updates are buffered in a DEPTH-entry circular FIFO and
//   drained in order whenever the BHT signals ready. Execute has no
//   backpressure, so an update that arrives while the queue is full, with no
//   drain in the same cycle, is dropped (newest lost) and counted.
//
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   flush_bp_i           empties the queue at the next edge, no drain
//   debug_mode_i         freezes the queue (no push, no drain)
//   res_*_i              resolved branch {pc, taken, index} from execute
//   upd_*_o, upd_ready_i head entry presented to the BHT, valid/ready
//   occupancy_o          stored entry count
//   drop_cnt_o           saturating count of dropped updates
module bht_update_queue #(
  parameter int unsigned VLEN   = 64,
  parameter int unsigned IDX_W  = 9,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_bp_i,
  input  logic                     debug_mode_i,
  input  logic                     res_valid_i,
  input  logic [VLEN-1:0]          res_pc_i,
  input  logic                     res_taken_i,
  input  logic [IDX_W-1:0]         res_index_i,
  output logic                     upd_valid_o,
  output logic [VLEN-1:0]          upd_pc_o,
  output logic                     upd_taken_o,
  output logic [IDX_W-1:0]         upd_index_o,
  input  logic                     upd_ready_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [DROP_W-1:0]        drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [VLEN-1:0]  pc;
    logic             taken;
    logic [IDX_W-1:0] idx;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic   accept, full, push, pop, drop;
  entry_t head;

  // Debug and flush both gate the head so nothing leaves the queue.
  assign upd_valid_o = (cnt_q != '0) && !debug_mode_i && !flush_bp_i;
  assign pop         = upd_valid_o && upd_ready_i;
  assign accept      = res_valid_i && !debug_mode_i && !flush_bp_i;
  assign full        = (cnt_q == CNT_W'(DEPTH));
  // A drain in the same cycle frees the slot even when full.
  assign push        = accept && (!full || pop);
  assign drop        = accept && full && !pop;

  assign head        = mem_q[rd_ptr_q];
  assign upd_pc_o    = head.pc;
  assign upd_taken_o = head.taken;
  assign upd_index_o = head.idx;
  assign occupancy_o = cnt_q;
  assign drop_cnt_o  = drop_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    if (flush_bp_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind upd_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= entry_t'{pc: res_pc_i, taken: res_taken_i, idx: res_index_i};
  end

endmodule

// File: tb/tb_bht_update_queue.sv
module tb_bht_update_queue;
  localparam int VLEN   = 64;
  localparam int IDX_W  = 9;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 4;
  localparam int MAXD   = (1 << DROP_W) - 1;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic fl = 1'b0, dbg = 1'b0, vld = 1'b0, tk = 1'b0, rdy = 1'b0;
  logic [VLEN-1:0] pc = '0;
  logic [IDX_W-1:0] ix = '0;
  logic upd_valid_o, upd_taken_o;
  logic [VLEN-1:0] upd_pc_o;
  logic [IDX_W-1:0] upd_index_o;
  logic [$clog2(DEPTH):0] occupancy_o;
  logic [DROP_W-1:0] drop_cnt_o;

  bht_update_queue #(.VLEN(VLEN), .IDX_W(IDX_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_bp_i(fl), .debug_mode_i(dbg),
    .res_valid_i(vld), .res_pc_i(pc), .res_taken_i(tk), .res_index_i(ix),
    .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
    .upd_index_o(upd_index_o), .upd_ready_i(rdy),
    .occupancy_o(occupancy_o), .drop_cnt_o(drop_cnt_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [VLEN-1:0]  pc;
    logic             tk;
    logic [IDX_W-1:0] ix;
  } ent_t;

  ent_t exp_q[$];
  int   mdrop  = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model + monitor. Outputs are sampled mid-cycle; the model then
  // applies this cycle's inputs so that it matches the DUT after the next edge.
  always @(negedge clk) begin
    bit   ev;
    ent_t e;
    if (!rst_ni) begin
      exp_q.delete();
      mdrop = 0;
    end else begin
      ev = (exp_q.size() != 0) && !dbg && !fl;
      chk("upd_valid", {63'd0, upd_valid_o}, {63'd0, ev});
      chk("occupancy", 64'(occupancy_o), 64'(exp_q.size()));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(mdrop));
      if (ev) begin
        chk("upd_pc", upd_pc_o, exp_q[0].pc);
        chk("upd_taken", {63'd0, upd_taken_o}, {63'd0, exp_q[0].tk});
        chk("upd_index", 64'(upd_index_o), 64'(exp_q[0].ix));
        if (rdy) void'(exp_q.pop_front());
      end
      if (fl) exp_q.delete();
      else if (vld && !dbg) begin
        if (exp_q.size() < DEPTH) begin
          e.pc = pc; e.tk = tk; e.ix = ix;
          exp_q.push_back(e);
        end else if (mdrop < MAXD) mdrop++;
      end
    end
  end

  task automatic drive(input bit v, input logic [63:0] p, input bit t, input logic [8:0] i,
                       input bit r, input bit f, input bit d);
    @(posedge clk); #1;
    vld = v; pc = p; tk = t; ix = i; rdy = r; fl = f; dbg = d;
  endtask

  task automatic idle(input bit r, input int n);
    repeat (n) drive(0, '0, 0, '0, r, 0, 0);
  endtask

  task automatic rpush(input bit r, input bit f, input bit d);
    drive(1, {$urandom, $urandom}, 1'($urandom), 9'($urandom), r, f, d);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    vld = 0; rdy = 0; fl = 0; dbg = 0;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_valid", {63'd0, upd_valid_o}, 64'd0);
    chk("rst_occupancy", 64'(occupancy_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
  endtask

  initial begin
    #12;
    chk("reset_valid", {63'd0, upd_valid_o}, 64'd0);
    chk("reset_occupancy", 64'(occupancy_o), 64'd0);
    chk("reset_drop", 64'(drop_cnt_o), 64'd0);
    @(posedge clk); #1 rst_ni = 1'b1;

    // single push, latency 1
    drive(1, 64'h80, 1, 9'd5, 1, 0, 0);
    idle(1, 3);

    // fill and overflow, head stable, then drain
    repeat (5) rpush(0, 0, 0);
    idle(0, 3);
    idle(1, 6);

    // full with simultaneous push/pop
    repeat (4) rpush(0, 0, 0);
    repeat (4) rpush(1, 0, 0);
    idle(1, 6);

    // flush with same-cycle push
    repeat (3) rpush(0, 0, 0);
    rpush(1, 1, 0);
    idle(1, 3);

    // debug freeze with pushes offered, then resume
    repeat (2) rpush(0, 0, 0);
    repeat (5) rpush(1, 0, 1);
    idle(1, 4);

    // drop=3, count=2, then reset mid-operation
    pulse_reset();
    repeat (7) rpush(0, 0, 0);
    idle(1, 2);
    pulse_reset();
    // pointer wrap: 3*DEPTH back-to-back push/pop pairs
    repeat (3 * DEPTH) rpush(1, 0, 0);
    idle(1, 4);

    // drop counter saturation
    repeat (MAXD + 5) rpush(0, 0, 0);
    idle(1, 6);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else begin
        bit d;
        d = ($urandom_range(0, 19) == 0) ? !dbg : dbg;
        drive($urandom_range(0, 9) < 6, {$urandom, $urandom}, 1'($urandom), 9'($urandom),
              $urandom_range(0, 9) < 5, $urandom_range(0, 49) == 0, d);
      end
    end
    idle(1, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 SHALL have parameter VLEN, default 64: virtual PC width.
REQ-002 SHALL have parameter IDX_W, default 9: BHT row-index width carried as metadata.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries, power of two, >=2.
REQ-004 SHALL have parameter DROP_W, default 8: drop-counter width.
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port flush_bp_i, input, 1: branch-predictor flush.
REQ-008 SHALL have port debug_mode_i, input, 1: core is in debug mode.
REQ-009 SHALL have port res_valid_i, input, 1: resolved branch from execute. There is no backpressure on this port.
REQ-010 SHALL have port res_pc_i, input, VLEN: PC of the resolved branch.
REQ-011 SHALL have port res_taken_i, input, 1: resolved direction.
REQ-012 SHALL have port res_index_i, input, IDX_W: BHT row index captured at prediction time.
REQ-013 SHALL have port upd_valid_o, output, 1: update presented to the BHT.
REQ-014 SHALL have port upd_pc_o, output, VLEN: head-entry PC.
REQ-015 SHALL have port upd_taken_o, output, 1: head-entry direction.
REQ-016 SHALL have port upd_index_o, output, IDX_W: head-entry row index.
REQ-017 SHALL have port upd_ready_i, input, 1: the BHT accepts the update this cycle.
REQ-018 SHALL have port occupancy_o, output, $clog2(DEPTH)+1: number of stored entries.
REQ-019 SHALL have port drop_cnt_o, output, DROP_W: count of discarded updates.

Function
REQ-020 SHALL store entries {pc, taken, index} in a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
REQ-021 SHALL push when res_valid_i=1 and debug_mode_i=0 and flush_bp_i=0 and (count<DEPTH or a pop occurs in the same cycle).
REQ-022 SHALL ignore res_valid_i without side effects while debug_mode_i=1.
REQ-023 SHALL drive upd_valid_o = (count!=0) && !debug_mode_i && !flush_bp_i; upd_*_o SHALL come combinationally from the head entry, which is registered storage.
REQ-024 SHALL pop the head when upd_valid_o && upd_ready_i.
REQ-025 SHALL give a latency of 1 cycle from push to the earliest upd_valid_o when the queue is empty; there is no bypass path.
REQ-026 SHALL hold upd_pc_o, upd_taken_o and upd_index_o stable while upd_valid_o=1 and upd_ready_i=0.
REQ-027 SHALL drop the incoming update (drop-newest) on a push attempt while full with no simultaneous pop, and SHALL leave the stored entries and the head unchanged.
REQ-028 SHALL increment drop_cnt_o by 1 per dropped update, saturating at 2^DROP_W-1.
REQ-029 SHALL accept both a push and a pop when they occur in the same cycle, including at count=DEPTH and count=1; count is unchanged and pointers advance independently.
REQ-030 SHALL, on flush_bp_i=1, set the pointers and count to 0 at the next edge, discard any same-cycle push, perform no pop, and leave drop_cnt_o unchanged.
REQ-031 SHALL, while debug_mode_i=1, retain the stored entries and resume draining in order when debug_mode_i returns to 0.
REQ-032 SHALL drive occupancy_o from the count register; the count SHALL never exceed DEPTH.
REQ-033 SHALL drain entries strictly in FIFO order; no coalescing or reordering is permitted.

Reset
REQ-034 SHALL, on rst_ni=0 and asynchronously, clear the pointers, count and drop counter, which gives upd_valid_o=0, occupancy_o=0 and drop_cnt_o=0.
REQ-035 SHALL reset entry storage only if required by the implementation; upd_*_o data is don't-care while upd_valid_o=0.
REQ-036 SHALL treat reset asserted mid-operation like a flush: all pending updates are lost and the drop counter is cleared.

Verification
REQ-037 Single push: push pc=0x80, taken=1, idx=5 with ready=1 -> at cycle+1 upd_valid_o=1 with the same fields; at cycle+2 occupancy_o=0.
REQ-038 Fill and overflow, DEPTH=4: ready=0, push 5 updates -> occupancy_o=4, drop_cnt_o=1; the head is the first update and stays stable; draining yields updates 1..4 in order.
REQ-039 Full plus simultaneous push/pop: count=4, ready=1, push -> no drop, occupancy_o stays 4, output order is preserved.
REQ-040 Flush: count=3, flush_bp_i=1 with a same-cycle push -> next cycle occupancy_o=0, upd_valid_o=0, drop_cnt_o unchanged.
REQ-041 Debug mode: 2 entries queued, debug_mode_i=1 for 5 cycles with pushes offered -> upd_valid_o=0 and occupancy_o=2 throughout; after debug exit both entries drain in order.
REQ-042 Reset mid-operation: drop_cnt_o=3 and count=2, pulse rst_ni low -> all outputs 0 immediately; pointer wrap is checked by 3*DEPTH push/pop pairs with no loss.
